// File: rtl/knn_sort_sched.sv
// Batch sorter for the KNN pipeline: loads N (distance, type) pairs, sorts them in place with one
// pipelined compare-exchange using odd-even transposition, then streams them out. Optional: KNN_SORT_EARLY_EXIT_EN.
module knn_sort_sched #(
  parameter int W      = 16,
  parameter int TYPE_W = 4,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_dist,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              ascending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_dist,
  output logic [TYPE_W-1:0] out_type,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_SORT = 2'd1, S_OUT = 2'd2} state_t;
  state_t state_q, state_d;

  logic [W-1:0]      dist_q [N];
  logic [TYPE_W-1:0] type_q [N];
  logic [IW-1:0]     ld_cnt, out_idx, phase, pair_cnt;
  logic              asc_q;

  logic              ce_valid;
  logic [IW-1:0]     ce_idx;
  logic [W-1:0]      ce_lo_d, ce_hi_d;
  logic [TYPE_W-1:0] ce_lo_t, ce_hi_t;

  logic              in_fire, out_fire, ld_last, issue, bubble, swap, last_phase, early;
  logic [IW-1:0]     pairs, iss_idx, iss_nxt, ce_nxt;
  logic [W-1:0]      a_d, b_d;
  logic [TYPE_W-1:0] a_t, b_t;

`ifdef KNN_SORT_EARLY_EXIT_EN
  logic phase_swap, prev_clean;
  assign early = prev_clean && !phase_swap;
`else
  assign early = 1'b0;
`endif

  // Handshake: a pair moves on a port exactly in a cycle where valid && ready; valid never depends on ready.
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign ld_last    = (ld_cnt == IW'(N-1));
  assign pairs      = phase[0] ? IW'(N/2 - 1) : IW'(N/2);
  assign issue      = (state_q == S_SORT) && (pair_cnt != pairs);
  assign bubble     = (state_q == S_SORT) && (pair_cnt == pairs);
  assign last_phase = (phase == IW'(N-1));
  assign iss_idx    = {pair_cnt[IW-2:0], phase[0]};
  assign iss_nxt    = iss_idx + ONE;
  assign ce_nxt     = ce_idx + ONE;
  assign a_d        = dist_q[iss_idx];
  assign b_d        = dist_q[iss_nxt];
  assign a_t        = type_q[iss_idx];
  assign b_t        = type_q[iss_nxt];
  assign swap       = asc_q ? (a_d > b_d) : (a_d < b_d);

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_LOAD);
  assign out_last  = (state_q == S_OUT) && (out_idx == IW'(N-1));
  assign out_dist  = (state_q == S_OUT) ? dist_q[out_idx] : '0;
  assign out_type  = (state_q == S_OUT) ? type_q[out_idx] : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (in_fire && ld_last) state_d = S_SORT;
      // The bubble lets the last writeback of a phase land before anything reads the buffer again.
      S_SORT: if (bubble && (last_phase || early)) state_d = S_OUT;
      S_OUT:  if (out_fire && out_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        dist_q[i] <= '0;
        type_q[i] <= '0;
      end
      ld_cnt   <= '0;
      out_idx  <= '0;
      phase    <= '0;
      pair_cnt <= '0;
      asc_q    <= 1'b1;
      ce_valid <= 1'b0;
      ce_idx   <= '0;
      ce_lo_d  <= '0;
      ce_hi_d  <= '0;
      ce_lo_t  <= '0;
      ce_hi_t  <= '0;
`ifdef KNN_SORT_EARLY_EXIT_EN
      phase_swap <= 1'b0;
      prev_clean <= 1'b0;
`endif
    end else begin
      ce_valid <= issue;
      if (issue) begin
        ce_idx   <= iss_idx;
        ce_lo_d  <= swap ? b_d : a_d;
        ce_hi_d  <= swap ? a_d : b_d;
        ce_lo_t  <= swap ? b_t : a_t;
        ce_hi_t  <= swap ? a_t : b_t;
        pair_cnt <= pair_cnt + ONE;
      end
      if (ce_valid) begin
        dist_q[ce_idx] <= ce_lo_d;
        dist_q[ce_nxt] <= ce_hi_d;
        type_q[ce_idx] <= ce_lo_t;
        type_q[ce_nxt] <= ce_hi_t;
      end
      if (bubble) begin
        pair_cnt <= '0;
        phase    <= phase + ONE;
      end
      if (in_fire) begin
        dist_q[ld_cnt] <= in_dist;
        type_q[ld_cnt] <= in_type;
        ld_cnt         <= ld_last ? '0 : ld_cnt + ONE;
        if (ld_cnt == '0) asc_q <= ascending;
        if (ld_last) begin
          phase    <= '0;
          pair_cnt <= '0;
        end
      end
      if (out_fire) out_idx <= out_last ? '0 : out_idx + ONE;
`ifdef KNN_SORT_EARLY_EXIT_EN
      if (issue && swap) phase_swap <= 1'b1;
      if (bubble) begin
        prev_clean <= !phase_swap;
        phase_swap <= 1'b0;
      end
      if (in_fire && ld_last) begin
        phase_swap <= 1'b0;
        prev_clean <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_knn_sort_sched.sv
// Directed bench for knn_sort_sched (N=8): ordering, ties, backpressure, mid-sort reset and sort length.
module tb_knn_sort_sched;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, ascending, out_valid, out_ready, out_last, busy;
  logic [W-1:0]  in_dist, out_dist;
  logic [TW-1:0] in_type, out_type;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W+TW-1:0] exp_q[$];
  logic [W-1:0]    ld_dist [N];
  logic [TW-1:0]   ld_type [N];
  logic [W-1:0]    ex_dist [N];
  logic [TW-1:0]   ex_type [N];

  knn_sort_sched #(.W(W), .TYPE_W(TW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dist(in_dist), .in_type(in_type), .ascending(ascending),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .out_type(out_type), .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back({ex_type[i], ex_dist[i]});
  endtask

  // ascending is only meaningful on the first pair; later pairs carry the opposite value on purpose.
  task automatic load_batch(input logic asc, input int gap);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gap > 0 && (i % 3) == 1) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid  = 1'b1;
      in_dist   = ld_dist[i];
      in_type   = ld_type[i];
      ascending = (i == 0) ? asc : !asc;
      chk("load_in_ready", in_ready, 1);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    ascending = 1'b0;
  endtask

  task automatic wait_first(input string tag, input int exp_lat, input int exp_sort);
    int  k = 0;
    int  sc = 0;
    bit  seen = 0;
    bit  rdy_seen = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (dbg_state == 2'd1) sc++;
      if (in_ready) rdy_seen = 1;
      if (out_valid) seen = 1;
    end
    chk({tag, "_first_out_seen"}, seen, 1);
    chk({tag, "_in_ready_low"}, rdy_seen, 0);
    if (exp_lat >= 0) chk({tag, "_latency"}, k, exp_lat);
    if (exp_sort >= 0) chk({tag, "_sort_cycles"}, sc, exp_sort);
  endtask

  task automatic drain(input string tag, input bit bp);
    int              n = 0;
    int              cyc = 0;
    bit              stalled = 0;
    logic [W-1:0]    hd;
    logic [TW-1:0]   ht;
    logic [W+TW-1:0] e;
    while (n < N && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (stalled) begin
        chk({tag, "_hold_dist"}, out_dist, hd);
        chk({tag, "_hold_type"}, out_type, ht);
      end
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_in_ready_out"}, in_ready, 0);
      out_ready = bp ? cyc[0] : 1'b1;
      if (out_ready) begin
        e = exp_q.pop_front();
        chk({tag, "_dist"}, out_dist, e[W-1:0]);
        chk({tag, "_type"}, out_type, e[W+TW-1:W]);
        chk({tag, "_last"}, out_last, (n == N-1));
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        hd = out_dist;
        ht = out_type;
      end
    end
    chk({tag, "_count"}, n, N);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_in_ready"}, in_ready, 1);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_state"}, dbg_state, 0);
  endtask

  task automatic set_desc();
    ld_dist = '{3, 9, 1, 7, 5, 2, 8, 4};
    ld_type = '{0, 1, 2, 3, 4, 5, 6, 7};
    ex_dist = '{9, 8, 7, 5, 4, 3, 2, 1};
    ex_type = '{1, 6, 3, 4, 7, 0, 5, 2};
    fill_exp();
  endtask

  initial begin
    int k;
    int sc;
    int lat_any;
    rst_n = 1'b0; in_valid = 1'b0; in_dist = '0; in_type = '0; ascending = 1'b1; out_ready = 1'b0;
`ifdef KNN_SORT_EARLY_EXIT_EN
    lat_any = -1;
`else
    lat_any = 37;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_dist", out_dist, 0);
    chk("rst_out_type", out_type, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // Reverse order, ascending: worst case, needs every phase.
    ld_dist = '{8, 7, 6, 5, 4, 3, 2, 1};
    ld_type = '{8, 7, 6, 5, 4, 3, 2, 1};
    ex_dist = '{1, 2, 3, 4, 5, 6, 7, 8};
    ex_type = '{1, 2, 3, 4, 5, 6, 7, 8};
    fill_exp();
    load_batch(1'b1, 0);
    wait_first("rev", 37, 36);
    drain("rev", 1'b0);

    // Descending with input gaps.
    set_desc();
    load_batch(1'b0, 2);
    wait_first("desc", lat_any, -1);
    drain("desc", 1'b0);

    // Ties keep their load order.
    ld_dist = '{5, 5, 5, 5, 2, 2, 2, 2};
    ld_type = '{0, 1, 2, 3, 4, 5, 6, 7};
    ex_dist = '{2, 2, 2, 2, 5, 5, 5, 5};
    ex_type = '{4, 5, 6, 7, 0, 1, 2, 3};
    fill_exp();
    load_batch(1'b1, 0);
    wait_first("ties", lat_any, -1);
    drain("ties", 1'b0);

    // Backpressure with extreme values and a tie.
    ld_dist = '{100, 3, 65535, 0, 42, 42, 7, 1000};
    ld_type = '{0, 1, 2, 3, 4, 5, 6, 7};
    ex_dist = '{0, 3, 7, 42, 42, 100, 1000, 65535};
    ex_type = '{3, 1, 6, 4, 5, 0, 7, 2};
    fill_exp();
    load_batch(1'b1, 0);
    wait_first("bp", lat_any, -1);
    drain("bp", 1'b1);

    // Reset in the 10th SORT cycle, then a fresh batch.
    set_desc();
    load_batch(1'b0, 0);
    k = 0;
    sc = 0;
    while (sc < 10 && k < 100) begin
      @(negedge clk);
      k++;
      if (dbg_state == 2'd1) sc++;
    end
    chk("midrst_reach_sort", sc, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_out_dist", out_dist, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_batch(1'b0, 0);
    wait_first("postrst", lat_any, -1);
    drain("postrst", 1'b0);

    // Already sorted input: sort length depends on the early-exit build.
    ld_dist = '{1, 2, 3, 4, 5, 6, 7, 8};
    ld_type = '{0, 1, 2, 3, 4, 5, 6, 7};
    ex_dist = '{1, 2, 3, 4, 5, 6, 7, 8};
    ex_type = '{0, 1, 2, 3, 4, 5, 6, 7};
    fill_exp();
    load_batch(1'b1, 0);
`ifdef KNN_SORT_EARLY_EXIT_EN
    wait_first("sorted", 10, 9);
`else
    wait_first("sorted", 37, 36);
`endif
    drain("sorted", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
